// File: rtl/serial_alu.sv
// Digit-serial ALU: W bits per cycle, LSB digit first, with a registered
// carry between digits and a valid/ready handshake on both sides.
module serial_alu #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co,
  output logic         ov,
  output logic         zero
);

  localparam int D  = N / W;
  localparam int KW = (D > 1) ? $clog2(D) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  generate
    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_cfg
      $fatal(1, "serial_alu: illegal N/W combination");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [2:0]    op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  s_q, s_d;
  logic          co_q, co_d;
  logic          ov_q, ov_d;
  logic          zero_q, zero_d;

  logic [W-1:0]  ad, bd, bx, dres;
  logic [W:0]    sum;
  logic          arith, cmsb_in;

  // Operands shift right each digit, so the live digit is always at bit 0.
  always_comb begin
    ad      = a_q[W-1:0];
    bd      = b_q[W-1:0];
    bx      = (op_q == OP_SUB) ? ~bd : bd;
    sum     = {1'b0, ad} + {1'b0, bx} + {{W{1'b0}}, carry_q};
    cmsb_in = ad[W-1] ^ bx[W-1] ^ sum[W-1];
    arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    case (op_q)
      OP_ADD,
      OP_SUB:  dres = sum[W-1:0];
      OP_AND:  dres = ad & bd;
      OP_OR:   dres = ad | bd;
      OP_XOR:  dres = ad ^ bd;
      default: dres = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    k_d     = k_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = (op == OP_SUB);
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        r_d     = N'({dres, r_q} >> W);
        carry_d = arith & sum[W];
        k_d     = k_q + 1'b1;
        if (k_q == KW'(D - 1)) begin
          state_d = DONE;
          s_d     = r_d;
          co_d    = arith & sum[W];
          ov_d    = arith & (cmsb_in ^ sum[W]);
          zero_d  = (r_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
  assign ov        = ov_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: cycle model plus directed and random operations,
// and latency checks on W=8 and W=1 instances.
module tb_serial_alu;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, co, ov, zero;
  logic [7:0] s;

  logic       iv8, ir8, vl8, co8, ov8, z8;
  logic [7:0] s8;
  logic       iv1, ir1, vl1, co1, ov1, z1;
  logic [7:0] s1;

  int checks = 0;
  int errors = 0;

  serial_alu #(.N(8), .W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov), .zero(zero));

  serial_alu #(.N(8), .W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a), .b(b), .op(op), .out_valid(vl8), .out_ready(1'b1),
    .s(s8), .co(co8), .ov(ov8), .zero(z8));

  serial_alu #(.N(8), .W(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .op(op), .out_valid(vl1), .out_ready(1'b1),
    .s(s1), .co(co1), .ov(ov1), .zero(z1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {s, co, ov, zero} from plain arithmetic
  function automatic logic [10:0] ref_op(input logic [7:0] x, y,
                                         input logic [2:0] o);
    logic [8:0] full;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: begin
        full = {1'b0, x} + {1'b0, y};
        r = full[7:0];
        c = full[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      default: r = 8'h00;
    endcase
    return {r, c, v, (r == 8'h00)};
  endfunction

  // Cycle-level model: idle / counting digits / holding result
  int          m_left = 0;
  bit          m_done = 0;
  bit          mvalid = 0;
  logic [10:0] e_res = '0;
  logic [10:0] pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 0;
      e_res  = '0;
      mvalid = 1;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        e_res  = pend;
      end
    end else if (in_valid) begin
      m_left = D;
      pend   = ref_op(a, b, op);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_in_ready", in_ready, (m_left == 0) && !m_done);
      chk("m_out_valid", out_valid, m_done);
      chk("m_s", s, e_res[10:3]);
      chk("m_co", co, e_res[2]);
      chk("m_ov", ov, e_res[1]);
      chk("m_zero", zero, e_res[0]);
    end
  end

  task automatic run_op(input logic [7:0] x, y, input logic [2:0] o,
                        input int hold, output logic [10:0] got);
    int lat;
    @(posedge clk); #1;
    a = x; b = y; op = o;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      op = 3'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, D);
    got = {s, co, ov, zero};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_res", {s, co, ov, zero}, got);
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("drain_valid", out_valid, 1'b0);
      chk("drain_ready", in_ready, 1'b1);
    end
  endtask

  task automatic wide(input int which, input int exp_lat);
    int   lat;
    logic v;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; op = 3'd0;
    if (which == 8) iv8 = 1'b1;
    else iv1 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    iv1 = 1'b0;
    lat = 0;
    v = (which == 8) ? vl8 : vl1;
    while (!v && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      v = (which == 8) ? vl8 : vl1;
    end
    if (which == 8) begin
      chk("w8_latency", lat, exp_lat);
      chk("w8_res", {s8, co8, ov8, z8}, {8'h00, 1'b1, 1'b1, 1'b1});
    end else begin
      chk("w1_latency", lat, exp_lat);
      chk("w1_res", {s1, co1, ov1, z1}, {8'h00, 1'b1, 1'b1, 1'b1});
    end
  endtask

  logic [10:0] got;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    iv8 = 1'b0; iv1 = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_res", {s, co, ov, zero}, 11'h000);

    chk("ref_add", ref_op(8'h7F, 8'h01, 3'd0), {8'h80, 3'b010});
    chk("ref_sub", ref_op(8'h03, 8'h05, 3'd1), {8'hFE, 3'b000});
    chk("ref_sub_eq", ref_op(8'h05, 8'h05, 3'd1), {8'h00, 3'b101});

    run_op(8'h7F, 8'h01, 3'd0, 0, got);
    chk("add_7f_01", got, {8'h80, 3'b010});
    run_op(8'h05, 8'h05, 3'd1, 0, got);
    chk("sub_eq", got, {8'h00, 3'b101});
    run_op(8'h03, 8'h05, 3'd1, 0, got);
    chk("sub_borrow", got, {8'hFE, 3'b000});
    run_op(8'hF0, 8'h3C, 3'd2, 0, got);
    chk("and", got, {8'h30, 3'b000});
    run_op(8'hFF, 8'hFF, 3'd4, 0, got);
    chk("xor_zero", got, {8'h00, 3'b001});
    run_op(8'h12, 8'h34, 3'd6, 0, got);
    chk("reserved", got, {8'h00, 3'b001});
    run_op(8'hFF, 8'h01, 3'd0, 5, got);
    chk("bp_add", got, {8'h00, 3'b101});
    run_op(8'h0A, 8'h05, 3'd3, 0, got);
    chk("or_after_bp", got, {8'h0F, 3'b000});

    // Abandon an operation in its second digit cycle
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h01; op = 3'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_res", {s, co, ov, zero}, 11'h000);
    run_op(8'h10, 8'h20, 3'd0, 0, got);
    chk("post_rst_add", got, {8'h30, 3'b000});

    for (int i = 0; i < 150; i++) begin
      run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3), got);
    end

    @(posedge clk); #1;
    wide(8, 1);
    wide(1, 8);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
